// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Program counter register for the microprocessor datapath. Captures the
// next-address value from the next-PC logic on every rising clock edge and
// presents it as the current instruction address. Also supplies PC+1
// (wrapping modulo 2^WIDTH) for the next-PC mux.
//
// Ports:
//   clk    in   1      system clock, all state updates on rising edge
//   reset  in   1      synchronous, active-high; loads RESET_VALUE
//   NextI  in   WIDTH  next program-counter value
//   stall  in   1      active-high hold of the current value
//   NextO  out  WIDTH  current program counter (registered)
//   NextP1 out  WIDTH  NextO + 1, truncated to WIDTH bits (combinational)
//
// Edge priority: reset > stall > load.
// ---------------------------------------------------------------------------
module program_counter #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] NextI,
  input  logic             stall,
  output logic [WIDTH-1:0] NextO,
  output logic [WIDTH-1:0] NextP1
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VALUE;
    end else if (!stall) begin
      r_pc <= NextI;
    end
  end

  // Same-width addition drops the carry, giving the modulo-2^WIDTH wrap.
  assign w_pc_inc = r_pc + ONE;

  assign NextO  = r_pc;
  assign NextP1 = w_pc_inc;

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//
// Directed bench for program_counter (WIDTH=8, RESET_VALUE=0). Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns after the rising edge
// that should have updated them.
// ---------------------------------------------------------------------------
module tb_program_counter;

  logic       clk;
  logic       reset;
  logic [7:0] NextI;
  logic       stall;
  logic [7:0] NextO;
  logic [7:0] NextP1;

  int total;
  int bad;

  program_counter #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .NextI  (NextI),
    .stall  (stall),
    .NextO  (NextO),
    .NextP1 (NextP1)
  );

  // 20 ns clock period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] exp_o, input logic [7:0] exp_p1);
    chk({tag, "_o"},  NextO,  exp_o);
    chk({tag, "_p1"}, NextP1, exp_p1);
  endtask

  logic [7:0] load_seq [4];
  logic [7:0] load_p1  [4];

  initial begin
    total = 0;
    bad   = 0;
    load_seq = '{8'h55, 8'h5F, 8'hF5, 8'hFF};
    load_p1  = '{8'h56, 8'h60, 8'hF6, 8'h00};

    reset = 1'b1;
    stall = 1'b0;
    NextI = 8'hAA;
    #1;

    // Reset held for two edges while NextI carries a non-zero value
    tick();
    chk_pc("reset_edge1", 8'h00, 8'h01);
    tick();
    chk_pc("reset_edge2", 8'h00, 8'h01);

    // Release reset: first edge loads NextI
    reset = 1'b0;
    NextI = 8'h55;
    tick();
    chk_pc("reset_release", 8'h55, 8'h56);

    // Load sequence, each value held for 100 ns (5 edges)
    for (int i = 0; i < 4; i++) begin
      NextI = load_seq[i];
      for (int e = 0; e < 5; e++) begin
        tick();
        chk_pc($sformatf("load%0d_e%0d", i, e), load_seq[i], load_p1[i]);
      end
    end

    // Wrap from 0xFF back to 0x00
    NextI = 8'h00;
    tick();
    chk_pc("wrap_to_zero", 8'h00, 8'h01);

    // Stall holds the value for three edges, release loads the pending value
    NextI = 8'h12;
    tick();
    chk_pc("stall_setup", 8'h12, 8'h13);
    stall = 1'b1;
    NextI = 8'h34;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk_pc($sformatf("stall_hold_e%0d", e), 8'h12, 8'h13);
    end
    stall = 1'b0;
    tick();
    chk_pc("stall_release", 8'h34, 8'h35);

    // Reset wins over stall
    NextI = 8'h77;
    tick();
    chk_pc("prio_setup", 8'h77, 8'h78);
    stall = 1'b1;
    reset = 1'b1;
    NextI = 8'h99;
    tick();
    chk_pc("prio_reset_over_stall", 8'h00, 8'h01);
    reset = 1'b0;
    tick();
    chk_pc("prio_stall_after_reset", 8'h00, 8'h01);
    stall = 1'b0;

    // Single-edge reset pulse in the middle of loading
    NextI = 8'hA0;
    tick();
    chk_pc("midrun_before", 8'hA0, 8'hA1);
    reset = 1'b1;
    NextI = 8'hA1;
    tick();
    chk_pc("midrun_reset", 8'h00, 8'h01);
    reset = 1'b0;
    tick();
    chk_pc("midrun_resume", 8'hA1, 8'hA2);

    // Reset pulse entirely between edges must be ignored
    NextI = 8'hB0;
    #3;
    reset = 1'b1;
    #5;
    reset = 1'b0;
    chk_pc("glitch_no_effect_yet", 8'hA1, 8'hA2);
    tick();
    chk_pc("glitch_ignored", 8'hB0, 8'hB1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 8-bit program counter register for the microprocessor datapath.
- Captures the next-address value computed by the next-PC logic on every rising clock edge and presents it as the current instruction address to instruction memory.
- Also provides a wrapped PC+1 value for the next-PC mux, and a stall input that freezes the counter.

Parameters:
- WIDTH, 8, address width in bits of NextI, NextO and NextP1.
- RESET_VALUE, 0, value loaded into NextO on reset (must fit in WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- NextI  input  WIDTH  next program-counter value from the next-PC logic.
- stall  input  1  active-high hold; tie 0 for unconditional load.
- NextO  output  WIDTH  current program counter (registered).
- NextP1  output  WIDTH  combinational NextO + 1, modulo 2^WIDTH.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Single register, NextO, updated only on rising edge of clk.
- Priority at each rising edge: reset > stall > load.
  - reset=1: NextO <= RESET_VALUE, regardless of stall or NextI.
  - reset=0, stall=1: NextO holds its value.
  - reset=0, stall=0: NextO <= NextI (full WIDTH bits, no modification).
- Latency: NextI sampled at edge k appears on NextO immediately after edge k; exactly one cycle.
- No combinational path from NextI to NextO.
- NextP1 = NextO + 1, truncated to WIDTH bits.
  - Purely combinational from NextO.
  - Wraps: 0xFF -> 0x00 for WIDTH=8.
- Reset deasserted mid-run: the first edge after deassertion loads NextI (or holds if stall=1).
- Asserting reset only between edges has no effect until the next rising edge.
- Before the first reset edge, NextO is unspecified. Simulation may show X; benches must not check NextO before reset.
- If NextI is X/Z and loaded, NextO propagates it. No sanitising.
- stall and reset are sampled only at the clock edge; glitches between edges are ignored.
- No other state, no enable other than stall, no asynchronous behaviour.

Test Plan:
- Reset: clk period 20 ns, reset=1 for 2 edges with NextI=0xAA -> NextO=0x00, NextP1=0x01; deassert reset with NextI=0x55 -> NextO=0x55 after next edge.
- Load sequence: stall=0, apply NextI = 0x55, 0x5F, 0xF5, 0xFF, each held for 100 ns -> NextO follows each value one edge after the change; NextP1 = 0x56, 0x60, 0xF6, 0x00 respectively.
- Wrap: NextI=0xFF loaded -> NextO=0xFF, NextP1=0x00. Then NextI=0x00 -> NextO=0x00, NextP1=0x01.
- Stall: NextO=0x12, stall=1, NextI=0x34 for 3 edges -> NextO stays 0x12. Drop stall -> NextO=0x34 after next edge.
- Reset priority: stall=1 and reset=1 with NextO=0x77 -> NextO=0x00 after the edge.
- Reset mid-run: reset=1 pulsed for one edge during the load sequence -> NextO=0x00 for exactly that cycle, then resumes tracking NextI.
